// File: rtl/ext_ram_banked.sv
// Banked single-clock RAM: NUM_BANKS independent arrays with one write port
// and one read port, write-first bypass, 1- or 2-cycle registered read data,
// and a background zero-fill that clears one address per cycle in every bank.
module ext_ram_banked #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_BANKS  = 4,
    parameter int RD_LATENCY = 1,
    localparam int BANK_W    = $clog2(NUM_BANKS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init_start,
    output logic                  busy,
    input  logic                  wr_en,
    input  logic [BANK_W-1:0]     wr_bank,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [BANK_W-1:0]     rd_bank,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);

    localparam int RAM_DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
    logic                    busy_q, busy_d;

    logic                    s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH-1:0]   s1_data_q, s1_data_d;
    logic                    rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;

    logic                    rd_fire;
    logic                    bypass;
    logic [DATA_WIDTH-1:0]   rd_word;

    // Storage is deliberately left without reset so an aborted clear keeps
    // whatever it had not reached yet.
    logic [DATA_WIDTH-1:0]   mem [NUM_BANKS][RAM_DEPTH];

    // Zero-fill sequencer: IDLE -> CLEAR on init_start, back after the last address.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        busy_d    = busy_q;
        unique case (state_q)
            ST_IDLE: begin
                if (init_start) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                    busy_d    = 1'b1;
                end
            end
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
                if (clr_cnt_q == '1) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Read request decode with write-first bypass and output stage selection.
    // For RD_LATENCY=1 the output register captures the request directly;
    // for RD_LATENCY=2 it captures the intermediate stage one cycle later.
    always_comb begin
        rd_fire    = rd_en & ~busy_q;
        bypass     = wr_en & ~busy_q & (wr_bank == rd_bank) & (wr_addr == rd_addr);
        rd_word    = bypass ? wr_data : mem[rd_bank][rd_addr];
        s1_valid_d = rd_fire;
        s1_data_d  = rd_fire ? rd_word : s1_data_q;
        if (RD_LATENCY == 1) begin
            rd_valid_d = rd_fire;
            rd_data_d  = rd_fire ? rd_word : rd_data_q;
        end else begin
            rd_valid_d = s1_valid_q;
            rd_data_d  = s1_valid_q ? s1_data_q : rd_data_q;
        end
    end

    // Control and read-pipeline registers, asynchronously reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            clr_cnt_q  <= '0;
            busy_q     <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            busy_q     <= busy_d;
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Memory write: clear all banks at the clear address, else the user write.
    always_ff @(posedge clk) begin
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            if (busy_q) begin
                mem[b][clr_cnt_q] <= '0;
            end else if (wr_en && (wr_bank == BANK_W'(b))) begin
                mem[b][wr_addr] <= wr_data;
            end
        end
    end

    assign busy     = busy_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_ext_ram_banked.sv
// Bench for ext_ram_banked: two instances (read latency 1 and 2) share the
// same stimulus and are compared every cycle against an array/queue model.
module tb_ext_ram_banked;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int NB    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          init_start = 1'b0;
    logic          wr_en = 1'b0;
    logic [1:0]    wr_bank = '0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic [1:0]    rd_bank = '0;
    logic [AW-1:0] rd_addr = '0;

    logic          busy1, busy2, rd_valid1, rd_valid2;
    logic [DW-1:0] rd_data1, rd_data2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ext_ram_banked #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BANKS(NB), .RD_LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .init_start(init_start), .busy(busy1),
        .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr(rd_addr),
        .rd_data(rd_data1), .rd_valid(rd_valid1));

    ext_ram_banked #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BANKS(NB), .RD_LATENCY(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .init_start(init_start), .busy(busy2),
        .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr(rd_addr),
        .rd_data(rd_data2), .rd_valid(rd_valid2));

    // ---------------- reference model ----------------
    typedef struct { int due; logic [DW-1:0] d; } pend_t;
    logic [DW-1:0] mem_m [NB][DEPTH];
    pend_t         q1[$];
    pend_t         q2[$];
    int            cyc = 0;
    int            clear_left = 0;
    int            clear_addr = 0;
    logic          e_busy = 1'b0, e_v1 = 1'b0, e_v2 = 1'b0;
    logic [DW-1:0] e_d1 = '0, e_d2 = '0;

    task automatic model_reset();
        clear_left = 0;
        clear_addr = 0;
        q1.delete();
        q2.delete();
        e_busy = 1'b0; e_v1 = 1'b0; e_v2 = 1'b0;
        e_d1 = '0; e_d2 = '0;
    endtask

    task automatic model_edge();
        logic [DW-1:0] val;
        pend_t p;
        cyc++;
        e_v1 = 1'b0;
        e_v2 = 1'b0;
        if (clear_left == 0) begin
            if (rd_en) begin
                val = (wr_en && wr_bank == rd_bank && wr_addr == rd_addr) ? wr_data : mem_m[rd_bank][rd_addr];
                q1.push_back('{due: cyc,     d: val});
                q2.push_back('{due: cyc + 1, d: val});
            end
            if (wr_en) mem_m[wr_bank][wr_addr] = wr_data;
            if (init_start) begin
                clear_left = DEPTH;
                clear_addr = 0;
            end
        end else begin
            for (int b = 0; b < NB; b++) mem_m[b][clear_addr] = '0;
            clear_addr++;
            clear_left--;
        end
        if (q1.size() > 0 && q1[0].due == cyc) begin
            p = q1.pop_front(); e_v1 = 1'b1; e_d1 = p.d;
        end
        if (q2.size() > 0 && q2[0].due == cyc) begin
            p = q2.pop_front(); e_v2 = 1'b1; e_d2 = p.d;
        end
        e_busy = (clear_left > 0);
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("busy_l1", 32'(busy1), 32'(e_busy));
        chk("busy_l2", 32'(busy2), 32'(e_busy));
        chk("valid_l1", 32'(rd_valid1), 32'(e_v1));
        chk("data_l1", 32'(rd_data1), 32'(e_d1));
        chk("valid_l2", 32'(rd_valid2), 32'(e_v2));
        chk("data_l2", 32'(rd_data2), 32'(e_d2));
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        check_model();
    endtask

    task automatic drive(input logic we, input logic [1:0] wb, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input logic re, input logic [1:0] rb,
                         input logic [AW-1:0] ra, input logic is);
        wr_en = we; wr_bank = wb; wr_addr = wa; wr_data = wd;
        rd_en = re; rd_bank = rb; rd_addr = ra; init_start = is;
    endtask

    task automatic idle();
        drive(1'b0, 2'd0, '0, '0, 1'b0, 2'd0, '0, 1'b0);
    endtask

    // ---------------- directed vectors (latency-1 instance) ----------------
    typedef struct {
        logic we; logic [1:0] wb; logic [AW-1:0] wa; logic [DW-1:0] wd;
        logic re; logic [1:0] rb; logic [AW-1:0] ra;
        logic ev; logic [DW-1:0] ed;
    } vec_t;
    vec_t vecs[7];

    initial begin
        int busy_cnt;
        int pulses;
        logic [DW-1:0] pat;

        vecs[0] = '{1'b1, 2'd2, 4'd3, 8'hA5, 1'b0, 2'd0, 4'd0, 1'b0, 8'h00};
        vecs[1] = '{1'b0, 2'd0, 4'd0, 8'h00, 1'b1, 2'd2, 4'd3, 1'b1, 8'hA5};
        vecs[2] = '{1'b1, 2'd1, 4'd7, 8'h11, 1'b0, 2'd0, 4'd0, 1'b0, 8'hA5};
        vecs[3] = '{1'b1, 2'd1, 4'd7, 8'h3C, 1'b1, 2'd1, 4'd7, 1'b1, 8'h3C};
        vecs[4] = '{1'b0, 2'd0, 4'd0, 8'h00, 1'b1, 2'd1, 4'd7, 1'b1, 8'h3C};
        vecs[5] = '{1'b0, 2'd0, 4'd0, 8'h00, 1'b1, 2'd0, 4'd0, 1'b1, 8'h00};
        vecs[6] = '{1'b0, 2'd0, 4'd0, 8'h00, 1'b0, 2'd0, 4'd0, 1'b0, 8'h00};

        for (int b = 0; b < NB; b++)
            for (int a = 0; a < DEPTH; a++) mem_m[b][a] = 'x;

        // reset state
        #1 rst_n = 1'b0;
        #2;
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_valid", 32'(rd_valid1), 32'd0);
        chk("rst_data", 32'(rd_data1), 32'd0);
        chk("rst_data_l2", 32'(rd_data2), 32'd0);
        model_reset();
        @(negedge clk) rst_n = 1'b1;

        // initial zero-fill so the array holds defined values
        drive(1'b0, 2'd0, '0, '0, 1'b0, 2'd0, '0, 1'b1);
        step();
        idle();
        repeat (DEPTH) step();

        // directed table
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].we, vecs[i].wb, vecs[i].wa, vecs[i].wd, vecs[i].re, vecs[i].rb, vecs[i].ra, 1'b0);
            step();
            chk($sformatf("tbl%0d_valid", i), 32'(rd_valid1), 32'(vecs[i].ev));
            chk($sformatf("tbl%0d_data", i), 32'(rd_data1), 32'(vecs[i].ed));
        end

        // latency 2: back-to-back reads of addr 0,1,2
        for (int a = 0; a < 3; a++) begin
            drive(1'b1, 2'd0, 4'(a), 8'(8'h10 + a), 1'b0, 2'd0, '0, 1'b0);
            step();
        end
        for (int a = 0; a < 5; a++) begin
            if (a < 3) drive(1'b0, 2'd0, '0, '0, 1'b1, 2'd0, 4'(a), 1'b0);
            else idle();
            step();
            chk($sformatf("lat2_valid%0d", a), 32'(rd_valid2), (a >= 1 && a <= 3) ? 32'd1 : 32'd0);
            if (a >= 1 && a <= 3) chk($sformatf("lat2_data%0d", a), 32'(rd_data2), 32'(8'h10 + a - 1));
        end

        // fill with FF, clear, busy length, all zero
        for (int i = 0; i < NB * DEPTH; i++) begin
            drive(1'b1, 2'(i / DEPTH), 4'(i % DEPTH), 8'hFF, 1'b0, 2'd0, '0, 1'b0);
            step();
        end
        drive(1'b0, 2'd0, '0, '0, 1'b0, 2'd0, '0, 1'b1);
        step();
        busy_cnt = 0;
        pulses = 0;
        for (int i = 0; i < 40 && busy1 === 1'b1; i++) begin
            // accesses while busy must be ignored
            drive(1'b1, 2'(i % NB), 4'(i % DEPTH), 8'h77, 1'b1, 2'(i % NB), 4'(i % DEPTH), 1'b1);
            busy_cnt++;
            step();
            if (rd_valid1 === 1'b1 || rd_valid2 === 1'b1) pulses++;
        end
        idle();
        chk("clear_busy_cycles", 32'(busy_cnt), 32'd16);
        chk("busy_rd_pulses", 32'(pulses), 32'd0);
        for (int i = 0; i < NB * DEPTH; i++) begin
            drive(1'b0, 2'd0, '0, '0, 1'b1, 2'(i / DEPTH), 4'(i % DEPTH), 1'b0);
            step();
            chk($sformatf("cleared_b%0d_a%0d", i / DEPTH, i % DEPTH), 32'(rd_data1), 32'd0);
        end
        idle();
        step();

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom), 2'($urandom), 4'($urandom), 8'($urandom),
                  1'($urandom), 2'($urandom), 4'($urandom), ($urandom_range(0, 99) == 0));
            step();
        end
        idle();
        repeat (DEPTH + 2) step();

        // reset in the middle of a clear, at clear address 5
        for (int i = 0; i < NB * DEPTH; i++) begin
            drive(1'b1, 2'(i / DEPTH), 4'(i % DEPTH), 8'(i + 1), 1'b0, 2'd0, '0, 1'b0);
            step();
        end
        drive(1'b0, 2'd0, '0, '0, 1'b0, 2'd0, '0, 1'b1);
        step();
        idle();
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy1), 32'd0);
        chk("midrst_valid", 32'(rd_valid1), 32'd0);
        chk("midrst_data", 32'(rd_data1), 32'd0);
        chk("midrst_data_l2", 32'(rd_data2), 32'd0);
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < NB * DEPTH; i++) begin
            drive(1'b0, 2'd0, '0, '0, 1'b1, 2'(i / DEPTH), 4'(i % DEPTH), 1'b0);
            step();
            pat = 8'(i + 1);
            if (i % DEPTH < 5) chk($sformatf("partial_b%0d_a%0d", i / DEPTH, i % DEPTH), 32'(rd_data1), 32'd0);
            else if (i % DEPTH > 5) chk($sformatf("partial_b%0d_a%0d", i / DEPTH, i % DEPTH), 32'(rd_data1), 32'(pat));
        end
        idle();
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ext_ram_banked.md
EXT_RAM_BANKED -- requirements
Module: ext_ram_banked

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, per-bank address width; RAM_DEPTH = 2**ADDR_WIDTH words per bank.
REQ-003 SHALL have parameter NUM_BANKS, default 4, power of two >= 2; BANK_W = log2(NUM_BANKS).
REQ-004 SHALL have parameter RD_LATENCY, default 1, legal values 1 or 2, read request-to-data cycles.
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port init_start  input  1  request zero-fill of all banks.
REQ-008 SHALL have port busy  output  1  high while zero-fill runs.
REQ-009 SHALL have port wr_en  input  1  write strobe.
REQ-010 SHALL have port wr_bank  input  BANK_W  write bank select.
REQ-011 SHALL have port wr_addr  input  ADDR_WIDTH  write address.
REQ-012 SHALL have port wr_data  input  DATA_WIDTH  write data.
REQ-013 SHALL have port rd_en  input  1  read strobe.
REQ-014 SHALL have port rd_bank  input  BANK_W  read bank select.
REQ-015 SHALL have port rd_addr  input  ADDR_WIDTH  read address.
REQ-016 SHALL have port rd_data  output  DATA_WIDTH  registered read data.
REQ-017 SHALL have port rd_valid  output  1  one-cycle pulse, rd_data valid.

Function
REQ-018 SHALL store NUM_BANKS independent arrays of RAM_DEPTH x DATA_WIDTH; one write port and one read port, usable in the same cycle on any banks.
REQ-019 SHALL, when wr_en=1 and busy=0, write wr_data to [wr_bank][wr_addr] at the clock edge.
REQ-020 SHALL, when rd_en=1 and busy=0, present [rd_bank][rd_addr] on rd_data with rd_valid=1 exactly RD_LATENCY cycles after the request edge; back-to-back reads every cycle SHALL be supported (full throughput).
REQ-021 SHALL, when read and write hit the same bank and address in the same cycle, return the new wr_data (write-first bypass).
REQ-022 SHALL hold rd_data at its last value when rd_valid=0.
REQ-023 SHALL implement FSM IDLE/CLEAR: IDLE->CLEAR when init_start=1; CLEAR->IDLE after address RAM_DEPTH-1 written.
REQ-024 SHALL, in CLEAR, write zero to one address per cycle in all banks simultaneously, addresses 0 to RAM_DEPTH-1 ascending; clear takes exactly RAM_DEPTH cycles.
REQ-025 SHALL drive busy=1 from the cycle after init_start is sampled in IDLE through the last CLEAR cycle.
REQ-026 SHALL ignore wr_en, rd_en and init_start while busy=1.
REQ-027 SHALL perform a read or write presented in the same cycle init_start is accepted; reads already in the pipeline SHALL complete with rd_valid.
REQ-028 SHALL treat wr_en/rd_en with init_start in IDLE as normal accesses; the clear SHALL overwrite any such write.

Reset
REQ-029 SHALL, on rst_n=0, immediately force FSM=IDLE, clear counter=0, busy=0, rd_valid=0, rd_data=0, read pipeline valids=0.
REQ-030 SHALL NOT reset memory contents; a reset during CLEAR SHALL abort leaving the array partially cleared.

Verification
REQ-031 Write 0xA5 to bank 2 addr 3, read bank 2 addr 3 next cycle (RD_LATENCY=1) -> rd_valid=1, rd_data=0xA5 one cycle after read.
REQ-032 Same cycle write 0x3C and read bank 1 addr 7 -> rd_data=0x3C (bypass), not prior value.
REQ-033 Fill all banks with 0xFF, pulse init_start (ADDR_WIDTH=4) -> busy high 16 cycles, then all 64 words read 0x00.
REQ-034 rd_en and wr_en during busy -> no rd_valid pulse, memory unchanged after clear completes.
REQ-035 RD_LATENCY=2, reads to addr 0,1,2 on consecutive cycles -> three consecutive rd_valid pulses starting 2 cycles after first request, data in order.
REQ-036 Assert rst_n=0 mid-clear at address 5 -> busy=0 immediately, rd_data=0, addresses 0-4 read 0x00, 6-15 retain old data.
